// File: rtl/cellrv32_pwm_seq_if.sv
// IO-bus port bundle for the PWM duty sequencer.
// Signals: addr_i (32), rden_i, wren_i, data_i (32) towards the slave;
//          data_o (32), ack_o back to the master.
interface cellrv32_pwm_seq_if;
  logic [31:0] addr_i;
  logic        rden_i;
  logic        wren_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (output addr_i, rden_i, wren_i, data_i, input  data_o, ack_o);
  modport slave  (input  addr_i, rden_i, wren_i, data_i, output data_o, ack_o);
endinterface

// File: rtl/cellrv32_pwm_seq.sv
// Duty-cycle sequencer: software queues 4x8-bit duty words in a FIFO; on each
// PWM period boundary one word is loaded into the selected duty group, so a
// duty update never tears mid-period.
// Ports: clk_i/rstn_i (async active-low), bus (IO-bus slave, 16-byte window
// at PWM_SEQ_BASE), period_i (PWM wrap pulse), dc_we_o/dc_sel_o/dc_data_o
// (one-cycle duty write towards the PWM), irq_o (level interrupt).
// Build option: define CELLRV32_PWM_SEQ_LOOP_EN to implement CTRL[16] LOOP
// (queued pattern replays forever instead of being consumed).
module cellrv32_pwm_seq #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] PWM_SEQ_BASE = 32'hFFFF_FF40
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  cellrv32_pwm_seq_if.slave bus,
  input  logic              period_i,
  output logic              dc_we_o,
  output logic [1:0]        dc_sel_o,
  output logic [31:0]       dc_data_o,
  output logic              irq_o
);

  localparam logic [31:0] pwm_seq_base_c = PWM_SEQ_BASE;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [7:0]    hold_cnt, hold_nxt;
  logic          ctrl_en, ctrl_irq_en, ctrl_loop;
  logic [1:0]    ctrl_sel, sel_eff;
  logic [7:0]    ctrl_repeat;
  logic          underrun, overrun;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_inc, rptr_nxt;
  logic [LW-1:0] level, remain;
  logic          acc, ctrl_we, stat_we, data_we, rd;
  logic          en_nxt, period_ok, load, underrun_set;
  logic          empty, full, busy, pop, push_ok, flush, resync;
  logic [31:0]   ctrl_rd, stat_rd;
  logic          unused_bits;

  // Bus decode: 16-byte window, word-aligned registers.
  assign acc     = (bus.addr_i[31:4] == pwm_seq_base_c[31:4]);
  assign rd      = acc & bus.rden_i;
  assign ctrl_we = acc & bus.wren_i & (bus.addr_i[3:2] == REG_CTRL);
  assign stat_we = acc & bus.wren_i & (bus.addr_i[3:2] == REG_STATUS);
  assign data_we = acc & bus.wren_i & (bus.addr_i[3:2] == REG_DATA);
  assign unused_bits = ^{bus.addr_i[1:0], bus.data_i};

  assign empty   = (level == LW'(0));
  assign full    = (level == LW'(FIFO_DEPTH));
  assign busy    = (state != IDLE);
  assign sel_eff = (ctrl_sel == 2'd3) ? 2'd2 : ctrl_sel;

  // EN as it will be after this cycle; any CTRL write masks the period pulse.
  assign en_nxt    = ctrl_we ? bus.data_i[0] : ctrl_en;
  assign period_ok = period_i & ~ctrl_we;
  assign flush     = ctrl_we & ~bus.data_i[0] & ctrl_en;

  // FIFO control; in loop mode a load only moves the read pointer.
  assign pop     = load & ~ctrl_loop;
  assign push_ok = data_we & ~(ctrl_loop & busy) & (~full | pop);
  assign resync  = ctrl_we & ctrl_loop & ~bus.data_i[16];
  assign remain  = LW'(wptr - rptr);

  // Loop-mode read pointer wraps back to the oldest queued entry.
  assign rptr_inc = rptr + AW'(1);
  always_comb begin
    rptr_nxt = rptr_inc;
    if (ctrl_loop && (rptr_inc == wptr)) rptr_nxt = wptr - AW'(level);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state and load decision.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    load         = 1'b0;
    underrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (en_nxt) begin
          state_nxt = RUN;
          hold_nxt  = 8'd0;
        end
      end
      RUN: begin
        if (period_ok) begin
          if (hold_cnt != 8'd0) begin
            hold_nxt = hold_cnt - 8'd1;
          end else if (!empty) begin
            load     = 1'b1;
            hold_nxt = ctrl_repeat;
          end else begin
            underrun_set = 1'b1;
            state_nxt    = STALL;
          end
        end
      end
      STALL: begin
        if (period_ok && !empty) begin
          load      = 1'b1;
          hold_nxt  = ctrl_repeat;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!en_nxt) begin
      state_nxt    = IDLE;
      hold_nxt     = 8'd0;
      load         = 1'b0;
      underrun_set = 1'b0;
    end
  end

`ifdef CELLRV32_PWM_SEQ_LOOP_EN
  // LOOP control bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      ctrl_loop <= 1'b0;
    else if (ctrl_we) ctrl_loop <= bus.data_i[16];
  end
`else
  assign ctrl_loop = 1'b0;
`endif

  // FIFO storage (no reset needed, validity tracked by level).
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= bus.data_i;
  end

  // Control/status registers, FIFO pointers, PWM-side and bus outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_en     <= 1'b0;
      ctrl_sel    <= 2'd0;
      ctrl_irq_en <= 1'b0;
      ctrl_repeat <= 8'd0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      dc_we_o     <= 1'b0;
      dc_sel_o    <= 2'd0;
      dc_data_o   <= 32'd0;
      irq_o       <= 1'b0;
      bus.ack_o   <= 1'b0;
      bus.data_o  <= 32'd0;
    end else begin
      if (ctrl_we) begin
        ctrl_en     <= bus.data_i[0];
        ctrl_sel    <= bus.data_i[2:1];
        ctrl_irq_en <= bus.data_i[3];
        ctrl_repeat <= bus.data_i[15:8];
      end
      // Event sets win over a same-cycle write-one-to-clear.
      underrun <= underrun_set | (underrun & ~(stat_we & bus.data_i[2]));
      overrun  <= (data_we & ~push_ok) | (overrun & ~(stat_we & bus.data_i[3]));

      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push_ok) wptr <= wptr + AW'(1);
        if (load)    rptr <= rptr_nxt;
        if (resync) begin
          if (remain != LW'(0)) level <= remain;
        end else if (push_ok && !pop) begin
          level <= level + LW'(1);
        end else if (pop && !push_ok) begin
          level <= level - LW'(1);
        end
      end

      dc_we_o <= load;
      if (load) begin
        dc_data_o <= mem[rptr];
        dc_sel_o  <= sel_eff;
      end

      irq_o     <= ctrl_en & ctrl_irq_en & (empty | underrun);
      bus.ack_o <= acc & (bus.rden_i | bus.wren_i);
      if (rd) begin
        case (bus.addr_i[3:2])
          REG_CTRL:   bus.data_o <= ctrl_rd;
          REG_STATUS: bus.data_o <= stat_rd;
          default:    bus.data_o <= 32'd0;
        endcase
      end else begin
        bus.data_o <= 32'd0;
      end
    end
  end

  // Register read images.
  always_comb begin
    ctrl_rd          = 32'd0;
    ctrl_rd[0]       = ctrl_en;
    ctrl_rd[2:1]     = ctrl_sel;
    ctrl_rd[3]       = ctrl_irq_en;
    ctrl_rd[15:8]    = ctrl_repeat;
    ctrl_rd[16]      = ctrl_loop;
    stat_rd          = 32'd0;
    stat_rd[0]       = empty;
    stat_rd[1]       = full;
    stat_rd[2]       = underrun;
    stat_rd[3]       = overrun;
    stat_rd[4]       = busy;
    stat_rd[8 +: LW] = level;
  end

endmodule
